// File: rtl/hc595_pkg.sv
// Shared constants and decode helpers for the 74HC595 link receiver.
// Glyph patterns are active-high, bit order g,f,e,d,c,b,a.
package hc595_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [6:0] GLYPH_0   = 7'h3F;
    localparam logic [6:0] GLYPH_1   = 7'h06;
    localparam logic [6:0] GLYPH_2   = 7'h5B;
    localparam logic [6:0] GLYPH_3   = 7'h4F;
    localparam logic [6:0] GLYPH_4   = 7'h66;
    localparam logic [6:0] GLYPH_5   = 7'h6D;
    localparam logic [6:0] GLYPH_6   = 7'h7D;
    localparam logic [6:0] GLYPH_7   = 7'h07;
    localparam logic [6:0] GLYPH_8   = 7'h7F;
    localparam logic [6:0] GLYPH_9   = 7'h6F;
    localparam logic [6:0] GLYPH_A   = 7'h77;
    localparam logic [6:0] GLYPH_B   = 7'h7C;
    localparam logic [6:0] GLYPH_C   = 7'h39;
    localparam logic [6:0] GLYPH_D   = 7'h5E;
    localparam logic [6:0] GLYPH_E   = 7'h79;
    localparam logic [6:0] GLYPH_F   = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Returns {valid, nibble}; anything other than a hex glyph (blank included) is invalid.
    function automatic logic [4:0] seg_to_hex(input logic [6:0] pattern);
        case (pattern)
            GLYPH_0: return {1'b1, 4'h0};
            GLYPH_1: return {1'b1, 4'h1};
            GLYPH_2: return {1'b1, 4'h2};
            GLYPH_3: return {1'b1, 4'h3};
            GLYPH_4: return {1'b1, 4'h4};
            GLYPH_5: return {1'b1, 4'h5};
            GLYPH_6: return {1'b1, 4'h6};
            GLYPH_7: return {1'b1, 4'h7};
            GLYPH_8: return {1'b1, 4'h8};
            GLYPH_9: return {1'b1, 4'h9};
            GLYPH_A: return {1'b1, 4'hA};
            GLYPH_B: return {1'b1, 4'hB};
            GLYPH_C: return {1'b1, 4'hC};
            GLYPH_D: return {1'b1, 4'hD};
            GLYPH_E: return {1'b1, 4'hE};
            GLYPH_F: return {1'b1, 4'hF};
            default: return 5'b0_0000;
        endcase
    endfunction

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser with a history flop and rising-edge detect.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic d_sync,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_in};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign d_sync = sync_q[STAGES-1];
    assign rise   = d_sync & ~hist_q;

endmodule

// File: rtl/hc595_frame_receiver.sv
// Receive side of the 74HC595 display link: shifts 16-bit frames on SCLK,
// commits on RCLK and decodes segment/select bytes back into hex digits.
module hc595_frame_receiver
    import hc595_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCLK,
    input  logic       RCLK,
    input  logic       DIO,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] dp,
    output logic [3:0] digit_seen,
    output logic [7:0] seg_raw,
    output logic [7:0] sel_raw,
    output logic       frame_strobe,
    output logic       err_bitcount,
    output logic       err_seg,
    output logic       err_sel
);

    logic sclk_rise, rclk_rise, dio_s;
    logic sclk_sync_unused, rclk_sync_unused, dio_rise_unused;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .rst(rst), .d_in(SCLK), .d_sync(sclk_sync_unused), .rise(sclk_rise)
    );
    sync_edge_det #(.STAGES(SYNC_STAGES)) u_rclk (
        .clk(clk), .rst(rst), .d_in(RCLK), .d_sync(rclk_sync_unused), .rise(rclk_rise)
    );
    // Same depth as SCLK so data and shift clock see identical skew.
    sync_edge_det #(.STAGES(SYNC_STAGES)) u_dio (
        .clk(clk), .rst(rst), .d_in(DIO), .d_sync(dio_s), .rise(dio_rise_unused)
    );

    logic [15:0] shreg;
    logic [4:0]  bitcnt;

    logic [7:0] seg_n, sel_n;
    logic [4:0] hex_dec;
    logic       cnt_bad, seg_bad, sel_bad;

    // Decode works on the pre-shift register, so a coincident SCLK edge cannot corrupt the latch.
    always_comb begin
        seg_n   = SEG_ACTIVE_LOW ? ~shreg[15:8] : shreg[15:8];
        sel_n   = SEL_ACTIVE_LOW ? ~shreg[7:0]  : shreg[7:0];
        hex_dec = seg_to_hex(seg_n[6:0]);
        cnt_bad = (bitcnt != 5'(FRAME_BITS));
        seg_bad = ~hex_dec[4];
        sel_bad = ~is_onehot4(sel_n[3:0]) | (|sel_n[7:4]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg        <= '0;
            bitcnt       <= '0;
            digit0       <= '0;
            digit1       <= '0;
            digit2       <= '0;
            digit3       <= '0;
            dp           <= '0;
            digit_seen   <= '0;
            seg_raw      <= '0;
            sel_raw      <= '0;
            frame_strobe <= 1'b0;
            err_bitcount <= 1'b0;
            err_seg      <= 1'b0;
            err_sel      <= 1'b0;
        end else begin
            frame_strobe <= 1'b0;
            err_bitcount <= 1'b0;
            err_seg      <= 1'b0;
            err_sel      <= 1'b0;

            if (sclk_rise)
                shreg <= {shreg[14:0], dio_s};

            if (rclk_rise)
                bitcnt <= sclk_rise ? 5'd1 : 5'd0;
            else if (sclk_rise && bitcnt != 5'd31)
                bitcnt <= bitcnt + 5'd1;

            if (rclk_rise) begin
                seg_raw      <= shreg[15:8];
                sel_raw      <= shreg[7:0];
                frame_strobe <= 1'b1;
                err_bitcount <= cnt_bad;
                err_seg      <= seg_bad;
                err_sel      <= sel_bad;
                if (!(cnt_bad || seg_bad || sel_bad)) begin
                    case (sel_n[3:0])
                        4'b0001: digit0 <= hex_dec[3:0];
                        4'b0010: digit1 <= hex_dec[3:0];
                        4'b0100: digit2 <= hex_dec[3:0];
                        4'b1000: digit3 <= hex_dec[3:0];
                        default: ;
                    endcase
                    for (int i = 0; i < 4; i++) begin
                        if (sel_n[i]) begin
                            dp[i]         <= seg_n[7];
                            digit_seen[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
